// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and framing constants.
// Used by both uart_rx and uart_tx.
package uart_pkg;

  localparam int DEFAULT_BAUD_MULT = 139;
  localparam int DATA_BITS         = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input pin.
// Resets to 1 so that an idle-high line reads as idle during and after reset.
module uart_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // NOTE: flops use non-blocking assignments so r_sync takes the old r_meta,
  // keeping two real stages between the pin and the output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, BAUD_MULT clocks per bit, one-cycle valid strobe.
// Define UART_RX_PARITY_EN to add an even-parity bit and the o_parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_MULT = DEFAULT_BAUD_MULT
) (
  input  logic       i_uart_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_data,
  output logic [7:0] o_byte_out,
  output logic       o_data_valid,
  output logic       o_rx_active,
  output logic       o_frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       o_parity_err
`endif
);

  localparam int         HALF_BIT    = (BAUD_MULT - 1) / 2;
  localparam logic [7:0] LP_LAST     = 8'(BAUD_MULT - 1);
  localparam logic [7:0] LP_HALF     = 8'(HALF_BIT);
  localparam logic [2:0] LP_LAST_BIT = 3'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam uart_state_t LP_AFTER_DATA = PARITY;
`else
  localparam uart_state_t LP_AFTER_DATA = STOP;
`endif

  logic        w_rx_s;
  logic        w_last;
  logic        w_par_bad;
  uart_state_t r_state;
  logic [7:0]  r_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_byte;
  logic        r_valid;
  logic        r_active;
  logic        r_ferr;
`ifdef UART_RX_PARITY_EN
  logic        r_par_bit;
  logic        r_perr;
`endif

  uart_sync2 u_sync (
    .i_clk   (i_uart_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_rx_data),
    .o_sync  (w_rx_s)
  );

  assign w_last = (r_cnt == LP_LAST);
`ifdef UART_RX_PARITY_EN
  assign w_par_bad = ^{r_shift, r_par_bit};
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      // NOTE: the shift register is a handful of flops, not a memory, so it
      // is reset along with everything else to keep a stale byte from leaking.
      r_shift   <= '0;
      r_byte    <= '0;
      r_valid   <= 1'b0;
      r_active  <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) begin
            r_state  <= START;
            r_active <= 1'b1;
          end
        end
        START: begin
          if (r_cnt == LP_HALF) begin
            r_cnt <= '0;
            if (!w_rx_s) begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
            end else begin
              r_state  <= IDLE;
              r_active <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DATA: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[7:1]};
            if (r_bit_cnt == LP_LAST_BIT) r_state <= LP_AFTER_DATA;
            else                          r_bit_cnt <= r_bit_cnt + 3'd1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_last) begin
            r_cnt     <= '0;
            r_par_bit <= w_rx_s;
            r_state   <= STOP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
`endif
        STOP: begin
          // Leaving mid-stop-bit lets IDLE catch a start edge right after it.
          if (w_last) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr   <= w_par_bad;
`endif
            if (w_rx_s) begin
              r_state <= IDLE;
              if (!w_par_bad) begin
                r_byte  <= r_shift;
                r_valid <= 1'b1;
              end
            end else begin
              r_ferr  <= 1'b1;
              r_state <= BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        BREAK: begin
          r_cnt <= '0;
          if (w_rx_s) r_state <= IDLE;
        end
        default: begin
          r_state  <= IDLE;
          r_cnt    <= '0;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign o_byte_out   = r_byte;
  assign o_data_valid = r_valid;
  assign o_rx_active  = r_active;
  assign o_frame_err  = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame table, timing/corner sequences and
// random frames scored against a frame-level expected-event queue.
module tb_uart_rx;

  localparam int BM = 16;
  localparam int HB = (BM - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int LATENCY = HB + 4 + (FRAME_BITS - 1) * BM;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] byte_out;
  logic       dv;
  logic       act;
  logic       ferr;
`ifdef UART_RX_PARITY_EN
  logic       perr;
`endif

  always #5 clk = ~clk;

  uart_rx #(.BAUD_MULT(BM)) dut (
    .i_uart_clk   (clk),
    .i_rst_n      (rst_n),
    .i_rx_data    (rx),
    .o_byte_out   (byte_out),
    .o_data_valid (dv),
    .o_rx_active  (act),
    .o_frame_err  (ferr)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err (perr)
`endif
  );

  typedef enum int {EV_VALID, EV_FERR, EV_PERR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         low_after;
    int         gap;
    ev_kind_t   exp_kind;
    logic [7:0] exp_byte;
  } vec_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  last_valid_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic pop_check(input ev_kind_t k);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", 32'(int'(k)) + 32'h100, 32'hFFFF);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(int'(k)), 32'(int'(e.kind)));
      check("byte_out", 32'(byte_out), 32'(e.data));
    end
  endtask

  // Passive monitor: every strobe must match the next expected event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dv || ferr) check("valid_err_overlap", 32'(dv & ferr), 32'd0);
      if (dv) begin
        last_valid_cyc = cyc;
        pop_check(EV_VALID);
      end
      if (ferr) pop_check(EV_FERR);
`ifdef UART_RX_PARITY_EN
      if (perr) pop_check(EV_PERR);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bits(input logic [7:0] d, input logic par, input logic stop);
    rx = 1'b0;
    tick(BM);
    for (int k = 0; k < 8; k++) begin
      rx = d[k];
      tick(BM);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    tick(BM);
`endif
    rx = stop;
    tick(BM);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bits(d, ^d, stop);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_out"}, 32'(byte_out), 32'd0);
    check({tag, "_valid"}, 32'(dv), 32'd0);
    check({tag, "_active"}, 32'(act), 32'd0);
    check({tag, "_frame_err"}, 32'(ferr), 32'd0);
`ifdef UART_RX_PARITY_EN
    check({tag, "_parity_err"}, 32'(perr), 32'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[6];
    logic [7:0] last_good;
    logic [7:0] d;
    int         c0;
    int         n_act;

    vecs = '{
      '{8'hA5, 1'b1,  0, 20, EV_VALID, 8'hA5},
      '{8'h00, 1'b1,  0,  0, EV_VALID, 8'h00},
      '{8'hFF, 1'b1,  0,  0, EV_VALID, 8'hFF},
      '{8'h81, 1'b1,  0, 20, EV_VALID, 8'h81},
      '{8'h3C, 1'b0, 40, 32, EV_FERR,  8'h81},
      '{8'h55, 1'b1,  0, 20, EV_VALID, 8'h55}
    };

    rst_n = 1'b0;
    rx    = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(4);

    // Frame table: good frames, back-to-back run, stop-low break, recovery.
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{vecs[i].exp_kind, vecs[i].exp_byte});
      send_frame(vecs[i].data, vecs[i].stop);
      if (vecs[i].low_after > 0) begin
        rx = 1'b0;
        tick(vecs[i].low_after);
      end
      rx = 1'b1;
      tick(vecs[i].gap);
    end
    tick(2 * BM);
    check("table_events_drained", 32'(exp_q.size()), 32'd0);

    // Start edge to valid strobe latency.
    tick(5);
    c0 = cyc;
    exp_q.push_back('{EV_VALID, 8'hC3});
    send_frame(8'hC3, 1'b1);
    rx = 1'b1;
    tick(BM);
    check("valid_latency", 32'(last_valid_cyc - c0), 32'(LATENCY));

    // Short low glitch on an idle line.
    tick(5);
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    n_act = 0;
    repeat (30) begin
      @(negedge clk);
      if (act) n_act++;
    end
    check("glitch_active_cycles", 32'(n_act), 32'(HB + 1));
    check("glitch_active_low", 32'(act), 32'd0);
    tick(1);

    // Reset in the middle of data bit 4 of 0x7E, then a clean 0x12.
    tick(5);
    d  = 8'h7E;
    rx = 1'b0;
    tick(BM);
    for (int k = 0; k < 4; k++) begin
      rx = d[k];
      tick(BM);
    end
    rx = d[4];
    tick(BM / 2);
    check("active_mid_frame", 32'(act), 32'd1);
    rst_n = 1'b0;
    tick(1);
    check_reset_outputs("midframe_reset");
    tick(2);
    rx    = 1'b1;
    rst_n = 1'b1;
    tick(4);
    exp_q.push_back('{EV_VALID, 8'h12});
    send_frame(8'h12, 1'b1);
    rx = 1'b1;
    tick(2 * BM);
    check("reset_events_drained", 32'(exp_q.size()), 32'd0);
    last_good = 8'h12;

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the parity bit must be 1.
    exp_q.push_back('{EV_VALID, 8'h07});
    send_bits(8'h07, 1'b1, 1'b1);
    rx = 1'b1;
    tick(BM);
    exp_q.push_back('{EV_PERR, 8'h07});
    send_bits(8'h07, 1'b0, 1'b1);
    rx = 1'b1;
    tick(2 * BM);
    check("parity_events_drained", 32'(exp_q.size()), 32'd0);
    last_good = 8'h07;
`endif

    // Random frames: mostly good, some with a low stop bit.
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        exp_q.push_back('{EV_FERR, last_good});
        send_frame(d, 1'b0);
        rx = 1'b1;
        tick(BM);
      end else begin
        exp_q.push_back('{EV_VALID, d});
        last_good = d;
        send_frame(d, 1'b1);
        rx = 1'b1;
        tick($urandom_range(0, 20));
      end
    end
    tick(2 * BM);
    check("random_events_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
